// File: rtl/frame_hdr_insert_cw16_if.sv
// Stream interfaces around frame_hdr_insert_cw16: the counted upstream beat stream
// (count/final_cnt) and the header-tagged downstream stream (thdr/tlast).
interface frame_cnt_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 32
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [15:0]            count;
    logic                   final_cnt;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (output tvalid, tdata, count, final_cnt, tuser, input tready);
    modport slave  (input tvalid, tdata, count, final_cnt, tuser, output tready);
endinterface

interface frame_hdr_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 32
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   thdr;
    logic                   tlast;

    modport master (output tvalid, tdata, tuser, thdr, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, thdr, tlast, output tready);
endinterface

// File: rtl/frame_hdr_insert_cw16.sv
// Inserts a {tuser[15:0], seq_num} header beat ahead of every count==0-delimited frame.
// Optional FRAME_HDR_DROP_CNT_EN adds a saturating drop_cnt of beats discarded while hunting.
module frame_hdr_insert_cw16 #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 32,
    parameter int SEQ_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        async_reset_n,
    frame_cnt_if.slave  s_axis,
    frame_hdr_if.master m_axis
`ifdef FRAME_HDR_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_SOF  = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic                   run_r;
    logic                   out_valid_r, out_hdr_r, out_last_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [TUSER_WIDTH-1:0] out_user_r;
    logic                   out_valid_s, out_hdr_s, out_last_s;
    logic [DATA_WIDTH-1:0]  out_data_s;
    logic [TUSER_WIDTH-1:0] out_user_s;
    logic                   hold_full_r, hold_last_r;
    logic [DATA_WIDTH-1:0]  hold_data_r;
    logic [TUSER_WIDTH-1:0] frame_tuser_r;
    logic [SEQ_WIDTH-1:0]   seq_num_r;
    logic                   err_flag_r;
    logic [DATA_WIDTH-1:0]  hdr_word_s;
    logic                   out_free_s, s_ready_s, s_fire_s, hunting_s;
    logic                   sof_hit_s, discard_s, hold_clr_s;

    assign out_free_s = ~out_valid_r | m_axis.tready;
    // run_r keeps tready low while in reset so every output reads 0 there
    assign s_ready_s  = run_r & out_free_s & ~hold_full_r & (state_r != ST_HDR);
    assign s_fire_s   = s_axis.tvalid & s_ready_s;
    assign hunting_s  = (state_r == ST_HUNT) | (state_r == ST_SOF);
    assign sof_hit_s  = s_fire_s & hunting_s & (s_axis.count == 16'd0);
    assign discard_s  = s_fire_s & hunting_s & (s_axis.count != 16'd0);

    assign s_axis.tready = s_ready_s;
    assign m_axis.tvalid = out_valid_r;
    assign m_axis.tdata  = out_data_r;
    assign m_axis.tuser  = out_user_r;
    assign m_axis.thdr   = out_hdr_r;
    assign m_axis.tlast  = out_last_r;

    // State register
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_HUNT: begin
                if (sof_hit_s) state_s = ST_HDR;
                else           state_s = ST_HUNT;
            end
            ST_SOF: begin
                if (sof_hit_s)      state_s = ST_HDR;
                else if (discard_s) state_s = ST_HUNT;
                else                state_s = ST_SOF;
            end
            // Header leaves while the held first beat moves into the output register
            ST_HDR: begin
                if (out_free_s) state_s = hold_last_r ? ST_SOF : ST_PAY;
                else            state_s = ST_HDR;
            end
            ST_PAY: begin
                if (s_fire_s && s_axis.final_cnt) state_s = ST_SOF;
                else                              state_s = ST_PAY;
            end
            default: state_s = ST_HUNT;
        endcase
    end

    // Output register next values; the header is loaded as soon as the count==0 beat is taken
    always_comb begin
        hdr_word_s                 = {DATA_WIDTH{1'b0}};
        hdr_word_s[31:16]          = s_axis.tuser[15:0];
        hdr_word_s[SEQ_WIDTH-1:0]  = seq_num_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_user_s  = out_user_r;
        out_hdr_s   = out_hdr_r;
        out_last_s  = out_last_r;
        hold_clr_s  = 1'b0;
        case (state_r)
            ST_HUNT, ST_SOF: begin
                if (sof_hit_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = hdr_word_s;
                    out_user_s  = s_axis.tuser;
                    out_hdr_s   = 1'b1;
                    out_last_s  = 1'b0;
                end else if (out_free_s) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            ST_HDR: begin
                if (out_free_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = hold_data_r;
                    out_user_s  = frame_tuser_r;
                    out_hdr_s   = 1'b0;
                    out_last_s  = hold_last_r;
                    hold_clr_s  = 1'b1;
                end else begin
                    hold_clr_s  = 1'b0;
                end
            end
            ST_PAY: begin
                if (s_fire_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = s_axis.tdata;
                    out_user_s  = frame_tuser_r;
                    out_hdr_s   = 1'b0;
                    out_last_s  = s_axis.final_cnt;
                end else if (out_free_s) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_user_r  <= {TUSER_WIDTH{1'b0}};
            out_hdr_r   <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_user_r  <= out_user_s;
            out_hdr_r   <= out_hdr_s;
            out_last_r  <= out_last_s;
        end
    end

    // Hold register, frame metadata, sequence number and error flag
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            run_r         <= 1'b0;
            hold_full_r   <= 1'b0;
            hold_last_r   <= 1'b0;
            hold_data_r   <= {DATA_WIDTH{1'b0}};
            frame_tuser_r <= {TUSER_WIDTH{1'b0}};
            seq_num_r     <= {SEQ_WIDTH{1'b0}};
            err_flag_r    <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (sof_hit_s) begin
                hold_full_r   <= 1'b1;
                hold_last_r   <= s_axis.final_cnt;
                hold_data_r   <= s_axis.tdata;
                frame_tuser_r <= s_axis.tuser;
            end else if (hold_clr_s) begin
                hold_full_r   <= 1'b0;
            end
            if (hold_clr_s) begin
                seq_num_r <= seq_num_r + SEQ_WIDTH'(1'b1);
            end
            err_flag_r <= err_flag_r | (discard_s & (state_r == ST_SOF));
        end
    end

`ifdef FRAME_HDR_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of beats discarded while hunting for a frame start
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            drop_cnt_r <= 16'd0;
        end else if (discard_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_frame_hdr_insert_cw16.sv
// Scoreboard bench for frame_hdr_insert_cw16; a second instance with SEQ_WIDTH=2 covers seq wrap.
module tb_frame_hdr_insert_cw16;
    typedef logic [65:0] beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_cnt_if #(.DATA_WIDTH(32), .TUSER_WIDTH(32)) up_if ();
    frame_hdr_if #(.DATA_WIDTH(32), .TUSER_WIDTH(32)) dn_if ();
    frame_cnt_if #(.DATA_WIDTH(32), .TUSER_WIDTH(32)) up2_if ();
    frame_hdr_if #(.DATA_WIDTH(32), .TUSER_WIDTH(32)) dn2_if ();
`ifdef FRAME_HDR_DROP_CNT_EN
    logic [15:0] drop_cnt, drop_cnt2;
`endif

    frame_hdr_insert_cw16 #(.DATA_WIDTH(32), .TUSER_WIDTH(32), .SEQ_WIDTH(16)) dut (
        .clk(clk), .async_reset_n(rst_n), .s_axis(up_if), .m_axis(dn_if)
`ifdef FRAME_HDR_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    frame_hdr_insert_cw16 #(.DATA_WIDTH(32), .TUSER_WIDTH(32), .SEQ_WIDTH(2)) dut2 (
        .clk(clk), .async_reset_n(rst_n), .s_axis(up2_if), .m_axis(dn2_if)
`ifdef FRAME_HDR_DROP_CNT_EN
        , .drop_cnt(drop_cnt2)
`endif
    );

    assign up2_if.tvalid    = up_if.tvalid;
    assign up2_if.tdata     = up_if.tdata;
    assign up2_if.count     = up_if.count;
    assign up2_if.final_cnt = up_if.final_cnt;
    assign up2_if.tuser     = up_if.tuser;
    assign dn2_if.tready    = dn_if.tready;

    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];
    logic [31:0] exp2_q[$];
    beat_t obs_mem [0:1023];
    logic [31:0] hdr2_mem [0:63];
    int obs_wr = 0;
    int obs_rd = 0;
    int hdr2_wr = 0;
    int hdr2_rd = 0;
    bit in_frame = 1'b0;
    logic [31:0] frame_user_m = 32'd0;
    logic [15:0] seq_m = 16'd0;
    logic [1:0] seq2_m = 2'd0;
    int drops_m = 0;
    int bp_mode = 0;
    bit bp_done = 1'b0;

    // Output capture for both instances
    always @(negedge clk) begin
        if (!rst_n) begin
            obs_wr  <= 0;
            hdr2_wr <= 0;
        end else begin
            if (dn_if.tvalid && dn_if.tready) begin
                obs_mem[obs_wr[9:0]] <= {dn_if.thdr, dn_if.tlast, dn_if.tuser, dn_if.tdata};
                obs_wr <= obs_wr + 1;
            end
            if (dn2_if.tvalid && dn2_if.tready && dn2_if.thdr) begin
                hdr2_mem[hdr2_wr[5:0]] <= dn2_if.tdata;
                hdr2_wr <= hdr2_wr + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1:       dn_if.tready = ~dn_if.tready;
                2:       dn_if.tready = 1'b0;
                default: dn_if.tready = 1'b1;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic beat_t mk(input logic h, input logic l, input logic [31:0] u, input logic [31:0] d);
        return {h, l, u, d};
    endfunction

    task automatic apply_reset();
        up_if.tvalid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        in_frame = 1'b0; seq_m = 16'd0; seq2_m = 2'd0; drops_m = 0;
        obs_rd = 0; hdr2_rd = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [15:0] cnt, input logic fin);
        logic [31:0] d, u;
        bit acc;
        acc = 1'b0;
        d = $urandom; u = $urandom;
        up_if.tvalid = 1'b1; up_if.count = cnt; up_if.final_cnt = fin;
        up_if.tdata = d; up_if.tuser = u;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (up_if.tready === 1'b1) acc = 1'b1;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout got=no_tready required=tready count=%0d", cnt);
        end else if (!in_frame) begin
            if (cnt == 16'd0) begin
                frame_user_m = u;
                exp_q.push_back(mk(1'b1, 1'b0, u, {u[15:0], seq_m}));
                exp2_q.push_back({u[15:0], 14'd0, seq2_m});
                seq_m++; seq2_m++;
                exp_q.push_back(mk(1'b0, fin, u, d));
                in_frame = !fin;
            end else begin
                drops_m++;
            end
        end else begin
            exp_q.push_back(mk(1'b0, fin, frame_user_m, d));
            if (fin) in_frame = 1'b0;
        end
    endtask

    task automatic send_frame(input int limit);
        for (int c = 0; c <= limit; c++) send_beat(16'(c), c == limit);
    endtask

    task automatic idle(input int n);
        up_if.tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            if (obs_wr - obs_rd >= exp_q.size()) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        up_if.tvalid = 1'b0; up_if.tdata = 32'd0; up_if.count = 16'd0;
        up_if.final_cnt = 1'b0; up_if.tuser = 32'd0; dn_if.tready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({dn_if.tvalid, dn_if.thdr, dn_if.tlast, up_if.tready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0000", {dn_if.tvalid, dn_if.thdr, dn_if.tlast, up_if.tready});
        end
        checks++;
        if ({dn_if.tdata, dn_if.tuser} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data got=%h required=0", {dn_if.tdata, dn_if.tuser});
        end
        apply_reset();
`ifdef FRAME_HDR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d required=0", drop_cnt); end
`endif
    endtask

    task automatic test_basic();
        bit ok; beat_t e, o;
        send_frame(3); send_frame(3); idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL basic_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_hunt();
        bit ok; beat_t e, o;
        apply_reset();
        send_beat(16'd2, 1'b0); send_beat(16'd3, 1'b1); send_frame(3); idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL hunt_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL hunt_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
`ifdef FRAME_HDR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'(drops_m)) begin failures++; $display("FAIL hunt_drop got=%0d required=%0d", drop_cnt, drops_m); end
`endif
    endtask

    task automatic test_backpressure();
        bit ok, stall; beat_t e, o; logic [66:0] snap, cur;
        bp_mode = 1; bp_done = 1'b0; stall = 1'b0; snap = 67'd0;
        fork
            begin send_frame(5); send_frame(2); idle(1); bp_done = 1'b1; end
            begin
                for (int g = 0; g < 600 && !bp_done; g++) begin
                    @(negedge clk);
                    cur = {dn_if.tvalid, dn_if.thdr, dn_if.tlast, dn_if.tuser, dn_if.tdata};
                    if (stall) begin
                        checks++;
                        if (cur !== snap) begin failures++; $display("FAIL stall_stable got=%h required=%h", cur, snap); end
                    end
                    stall = dn_if.tvalid && !dn_if.tready;
                    snap = cur;
                end
            end
        join
        bp_mode = 0; idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL bp_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
        idle(10);
        checks++;
        if (obs_wr != obs_rd) begin failures++; $display("FAIL bp_extra got=%0d required=0", obs_wr - obs_rd); end
    endtask

    task automatic test_single_beat();
        bit ok; beat_t e, o;
        apply_reset();
        for (int i = 0; i < 4; i++) send_beat(16'd0, 1'b1);
        idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL single_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_framing_err();
        bit ok; beat_t e, o;
        apply_reset();
        checks++;
        if (dut.err_flag_r !== 1'b0) begin failures++; $display("FAIL err_clear got=%b required=0", dut.err_flag_r); end
        send_frame(2); send_beat(16'd5, 1'b0); send_frame(1); idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ferr_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL ferr_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (dut.err_flag_r !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b required=1", dut.err_flag_r); end
`ifdef FRAME_HDR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'(drops_m)) begin failures++; $display("FAIL ferr_drop got=%0d required=%0d", drop_cnt, drops_m); end
`endif
    endtask

    task automatic test_seq_wrap();
        bit ok; beat_t e, o; logic [31:0] e2, o2;
        apply_reset();
        for (int f = 0; f < 5; f++) send_frame(1);
        idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL wrap_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
        while (exp2_q.size() > 0) begin
            e2 = exp2_q.pop_front(); checks++;
            if (hdr2_rd >= hdr2_wr) begin
                failures++; $display("FAIL seq2_missing got=none required=%h", e2);
            end else begin
                o2 = hdr2_mem[hdr2_rd[5:0]]; hdr2_rd++;
                if (o2 !== e2) begin failures++; $display("FAIL seq2_hdr got=%h required=%h", o2, e2); end
            end
        end
    endtask

    task automatic test_reset_pay();
        bit ok; beat_t e, o;
        apply_reset();
        send_beat(16'd0, 1'b0); send_beat(16'd1, 1'b0); send_beat(16'd2, 1'b0); idle(4);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rpay_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL rpay_beat got=%h required=%h", o, e); end
        end
        bp_mode = 2; @(posedge clk); #2;
        send_beat(16'd3, 1'b0); up_if.tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (dn_if.tvalid !== 1'b1) begin failures++; $display("FAIL rpay_stalled got=%b required=1", dn_if.tvalid); end
        rst_n = 1'b0; #1;
        checks++;
        if ({dn_if.tvalid, dn_if.thdr, dn_if.tlast, dn_if.tdata, dn_if.tuser} !== 67'd0) begin
            failures++;
            $display("FAIL rpay_zero got=%h required=0", {dn_if.tvalid, dn_if.thdr, dn_if.tlast, dn_if.tdata, dn_if.tuser});
        end
        bp_mode = 0;
        apply_reset();
        send_frame(1); idle(6);
        wait_outputs(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rpost_count got=%0d required=%0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_wr > obs_rd) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd[9:0]]; obs_rd++; checks++;
            if (o !== e) begin failures++; $display("FAIL rpost_beat got=%h required=%h", o, e); end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hunt();
        test_backpressure();
        test_single_beat();
        test_framing_err();
        test_seq_wrap();
        test_reset_pay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
